// File: rtl/weight_loader_pkg.sv
// weight_loader_pkg: shared definitions for the weight/bias stream loader.
//   - FSM state encoding (CHK exists only with WEIGHT_LOADER_CHECKSUM_EN)
//   - header field positions: [31:24] layer, [23:16] neuron, [15:0] count
//   - CNT_W: drop-counter width (N+1, plus checksum word, must fit)
package weight_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR    = 3'd0,
    ST_WEIGHT = 3'd1,
    ST_BIAS   = 3'd2,
    ST_DRAIN  = 3'd3
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    ST_CHK    = 3'd4
`endif
  } state_e;

  localparam int unsigned LAYER_MSB  = 31;
  localparam int unsigned LAYER_LSB  = 24;
  localparam int unsigned NEURON_MSB = 23;
  localparam int unsigned NEURON_LSB = 16;
  localparam int unsigned COUNT_MSB  = 15;
  localparam int unsigned COUNT_LSB  = 0;

  localparam int unsigned LAYER_W  = LAYER_MSB - LAYER_LSB + 1;
  localparam int unsigned NEURON_W = NEURON_MSB - NEURON_LSB + 1;
  localparam int unsigned COUNT_W  = COUNT_MSB - COUNT_LSB + 1;

  localparam int unsigned CNT_W = 17;

endpackage

// File: rtl/weight_loader_hdr_check.sv
// weight_loader_hdr_check: combinational header decoder.
// Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN (adds the checksum word
// to the number of words a malformed frame must drop).
// Ports:
//   hdr_i       header word
//   layer_o     target layer field
//   neuron_o    target neuron field
//   count_o     weight count N
//   hdr_ok_o    1 <= N <= MAX_WEIGHT
//   drop_cnt_o  words to discard after a bad header
module weight_loader_hdr_check
  import weight_loader_pkg::*;
#(
  parameter int unsigned MAX_WEIGHT = 784
) (
  input  logic [31:0]         hdr_i,
  output logic [LAYER_W-1:0]  layer_o,
  output logic [NEURON_W-1:0] neuron_o,
  output logic [COUNT_W-1:0]  count_o,
  output logic                hdr_ok_o,
  output logic [CNT_W-1:0]    drop_cnt_o
);

  localparam logic [COUNT_W-1:0] MAX_N = COUNT_W'(MAX_WEIGHT);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam logic [CNT_W-1:0] TRAIL = CNT_W'(2);  // bias + checksum
`else
  localparam logic [CNT_W-1:0] TRAIL = CNT_W'(1);  // bias
`endif

  always_comb begin
    layer_o    = hdr_i[LAYER_MSB:LAYER_LSB];
    neuron_o   = hdr_i[NEURON_MSB:NEURON_LSB];
    count_o    = hdr_i[COUNT_MSB:COUNT_LSB];
    hdr_ok_o   = (count_o != '0) && (count_o <= MAX_N);
    // N==0 leaves only the trailing words; an oversized N drops its weights too.
    drop_cnt_o = {{(CNT_W - COUNT_W){1'b0}}, count_o} + TRAIL;
  end

endmodule

// File: rtl/weight_loader.sv
// weight_loader: parses a framed 32-bit word stream (header, N weights, bias)
// and drives the broadcast neuron weight/bias load interface.
// Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN (trailing XOR checksum word).
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   load_en             stream enable, mirrored on s_ready
//   s_data/s_valid      stream word and valid; s_ready stream ready
//   weightValid/Value   one-cycle weight pulse and data (dataWidth bits, zero-extended)
//   biasValid/Value     one-cycle bias pulse and data
//   config_layer_num    target layer, zero-extended
//   config_neuron_num   target neuron, zero-extended
//   busy                frame in progress
//   frame_done          pulse on good frame completion
//   frames_loaded       good-frame counter (wraps)
//   err                 sticky malformed-frame flag
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned maxWeight = 784,
  parameter int unsigned dataWidth = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        weightValid,
  output logic [31:0] weightValue,
  output logic        biasValid,
  output logic [31:0] biasValue,
  output logic [31:0] config_layer_num,
  output logic [31:0] config_neuron_num,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frames_loaded,
  output logic        err
);

  localparam logic [31:0] DATA_MASK =
    (dataWidth >= 32) ? '1 : ((32'd1 << dataWidth) - 32'd1);

  state_e              state_q, state_d;
  logic [COUNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic                wv_q, wv_d;
  logic [31:0]         wval_q, wval_d;
  logic                bv_q, bv_d;
  logic [31:0]         bval_q, bval_d;
  logic [31:0]         layer_q, layer_d;
  logic [31:0]         neuron_q, neuron_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         frames_q, frames_d;
  logic                err_q, err_d;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [31:0]         csum_q, csum_d;
`endif

  logic                accept;
  logic [LAYER_W-1:0]  hdr_layer;
  logic [NEURON_W-1:0] hdr_neuron;
  logic [COUNT_W-1:0]  hdr_count;
  logic                hdr_ok;
  logic [CNT_W-1:0]    hdr_drop;

  assign s_ready = load_en;
  assign accept  = s_valid & load_en;

  weight_loader_hdr_check #(
    .MAX_WEIGHT (maxWeight)
  ) u_hdr_check (
    .hdr_i      (s_data),
    .layer_o    (hdr_layer),
    .neuron_o   (hdr_neuron),
    .count_o    (hdr_count),
    .hdr_ok_o   (hdr_ok),
    .drop_cnt_o (hdr_drop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_HDR;
      rem_q    <= '0;
      drop_q   <= '0;
      wv_q     <= 1'b0;
      wval_q   <= '0;
      bv_q     <= 1'b0;
      bval_q   <= '0;
      layer_q  <= '0;
      neuron_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      frames_q <= '0;
      err_q    <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      drop_q   <= drop_d;
      wv_q     <= wv_d;
      wval_q   <= wval_d;
      bv_q     <= bv_d;
      bval_q   <= bval_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      frames_q <= frames_d;
      err_q    <= err_d;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    drop_d   = drop_q;
    wv_d     = 1'b0;
    wval_d   = wval_q;
    bv_d     = 1'b0;
    bval_d   = bval_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    frames_d = frames_q;
    err_d    = err_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    // No accept means a stall: everything holds and no pulse is produced.
    if (accept) begin
      case (state_q)
        ST_HDR: begin
          busy_d = 1'b1;
          if (hdr_ok) begin
            layer_d  = {{(32 - LAYER_W){1'b0}}, hdr_layer};
            neuron_d = {{(32 - NEURON_W){1'b0}}, hdr_neuron};
            rem_d    = hdr_count;
            state_d  = ST_WEIGHT;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            csum_d   = s_data;
`endif
          end else begin
            err_d   = 1'b1;
            drop_d  = hdr_drop;
            state_d = ST_DRAIN;
          end
        end
        ST_WEIGHT: begin
          wv_d   = 1'b1;
          wval_d = s_data & DATA_MASK;
          rem_d  = rem_q - 1'b1;
          if (rem_q == COUNT_W'(1)) begin
            state_d = ST_BIAS;
          end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ s_data;
`endif
        end
        ST_BIAS: begin
          bv_d   = 1'b1;
          bval_d = s_data & DATA_MASK;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ s_data;
          state_d = ST_CHK;
`else
          done_d   = 1'b1;
          frames_d = frames_q + 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_HDR;
`endif
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (s_data == csum_q) begin
            done_d   = 1'b1;
            frames_d = frames_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
          busy_d  = 1'b0;
          state_d = ST_HDR;
        end
`endif
        ST_DRAIN: begin
          drop_d = drop_q - 1'b1;
          if (drop_q == CNT_W'(1)) begin
            busy_d  = 1'b0;
            state_d = ST_HDR;
          end
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  assign weightValid       = wv_q;
  assign weightValue       = wval_q;
  assign biasValid         = bv_q;
  assign biasValue         = bval_q;
  assign config_layer_num  = layer_q;
  assign config_neuron_num = neuron_q;
  assign busy              = busy_q;
  assign frame_done        = done_q;
  assign frames_loaded     = frames_q;
  assign err               = err_q;

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: scoreboard bench for weight_loader.
// Honours WEIGHT_LOADER_CHECKSUM_EN (appends checksum words, runs CHK tests).
module tb_weight_loader;

  localparam int unsigned MAXW = 784;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        weightValid;
  logic [31:0] weightValue;
  logic        biasValid;
  logic [31:0] biasValue;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic        busy;
  logic        frame_done;
  logic [15:0] frames_loaded;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [31:0] exp_layer  = '0;
  logic [31:0] exp_neuron = '0;
  logic [31:0] wq[$];
  logic [31:0] bq[$];

  always #5 clk = ~clk;

  weight_loader #(
    .maxWeight (MAXW),
    .dataWidth (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .load_en           (load_en),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .weightValid       (weightValid),
    .weightValue       (weightValue),
    .biasValid         (biasValid),
    .biasValue         (biasValue),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .busy              (busy),
    .frame_done        (frame_done),
    .frames_loaded     (frames_loaded),
    .err               (err)
  );

  // Output monitor: pops the scoreboard whenever the DUT pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (weightValid) begin
        n_assert++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL weight_unexpected: got weightValue=%h with nothing expected", weightValue);
        end else begin
          logic [31:0] e;
          e = wq.pop_front();
          if (weightValue !== e) begin
            n_fail++;
            $display("FAIL weight_value: got %h expected %h", weightValue, e);
          end
        end
        n_assert++;
        if (config_layer_num !== exp_layer || config_neuron_num !== exp_neuron) begin
          n_fail++;
          $display("FAIL weight_config: got layer=%h neuron=%h expected layer=%h neuron=%h",
                   config_layer_num, config_neuron_num, exp_layer, exp_neuron);
        end
      end
      if (biasValid) begin
        n_assert++;
        if (bq.size() == 0) begin
          n_fail++;
          $display("FAIL bias_unexpected: got biasValue=%h with nothing expected", biasValue);
        end else begin
          logic [31:0] e;
          e = bq.pop_front();
          if (biasValue !== e) begin
            n_fail++;
            $display("FAIL bias_value: got %h expected %h", biasValue, e);
          end
        end
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    s_valid = 1'b0;
    load_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wq.delete();
    bq.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [31:0] w);
    s_data  = w;
    s_valid = 1'b1;
    load_en = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  // Good frame with weights base, base+1, ...; checksum word appended if enabled.
  task automatic send_good(input logic [31:0] hdr, input int n, input logic [31:0] base,
                           input logic [31:0] bias, input logic corrupt);
    logic [31:0] x;
    x = hdr;
    exp_layer  = {24'd0, hdr[31:24]};
    exp_neuron = {24'd0, hdr[23:16]};
    send(hdr);
    for (int i = 0; i < n; i++) begin
      wq.push_back((base + i) & 32'hFFFF);
      x = x ^ (base + i);
      send(base + i);
    end
    bq.push_back(bias & 32'hFFFF);
    x = x ^ bias;
    send(bias);
    if (CSUM != 0) send(corrupt ? ~x : x);
  endtask

  task automatic flush_and_check(input string name, input int exp_done, input logic [15:0] exp_frames,
                                 input logic exp_err);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert++;
    if (wq.size() != 0 || bq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: got %0d weights %0d biases outstanding, expected 0", name, wq.size(), bq.size());
    end
    n_assert++;
    if (done_cnt != exp_done) begin
      n_fail++;
      $display("FAIL %s_frame_done: got %0d pulses expected %0d", name, done_cnt, exp_done);
    end
    n_assert++;
    if (frames_loaded !== exp_frames) begin
      n_fail++;
      $display("FAIL %s_frames_loaded: got %0d expected %0d", name, frames_loaded, exp_frames);
    end
    n_assert++;
    if (err !== exp_err || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_err_busy: got err=%b busy=%b expected err=%b busy=0", name, err, busy, exp_err);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_assert++;
    if ({weightValid, biasValid, busy, frame_done, err, frames_loaded, weightValue, biasValue,
         config_layer_num, config_neuron_num} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got wv=%b bv=%b busy=%b done=%b err=%b frames=%h wval=%h bval=%h layer=%h neuron=%h expected all 0",
               weightValid, biasValid, busy, frame_done, err, frames_loaded, weightValue, biasValue,
               config_layer_num, config_neuron_num);
    end
  endtask

  task automatic test_good_frame();
    do_reset();
    exp_layer = 32'd1;
    exp_neuron = 32'd4;
    send(32'h0104_0003);
    @(negedge clk);
    n_assert++;
    if (config_layer_num !== 32'd1 || config_neuron_num !== 32'd4 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL good_config_early: got layer=%h neuron=%h busy=%b expected 1 4 1",
               config_layer_num, config_neuron_num, busy);
    end
    for (int i = 0; i < 3; i++) begin
      wq.push_back(32'hA + i);
      send(32'hA + i);
    end
    bq.push_back(32'hE90);
    send(32'hE90);
    if (CSUM != 0) send(32'h0104_0003 ^ 32'hA ^ 32'hB ^ 32'hC ^ 32'hE90);
    flush_and_check("good", 1, 16'd1, 1'b0);
  endtask

  task automatic test_stall();
    logic [31:0] words [8];
    int total;
    int idx;
    int cyc;
    do_reset();
    words[0] = 32'h0307_0005;
    for (int i = 0; i < 5; i++) words[1 + i] = 32'h100 + i;
    words[6] = 32'h55;
    words[7] = 32'h0307_0005 ^ 32'h100 ^ 32'h101 ^ 32'h102 ^ 32'h103 ^ 32'h104 ^ 32'h55;
    total = 7 + CSUM;
    for (int i = 0; i < 5; i++) wq.push_back(32'h100 + i);
    bq.push_back(32'h55);
    exp_layer = 32'd3;
    exp_neuron = 32'd7;
    idx = 0;
    cyc = 0;
    while (idx < total && cyc < 400) begin
      s_data  = words[idx];
      s_valid = 1'($urandom_range(0, 1));
      load_en = 1'($urandom_range(0, 1));
      #1;
      n_assert++;
      if (s_ready !== load_en) begin
        n_fail++;
        $display("FAIL stall_s_ready: got %b expected %b", s_ready, load_en);
      end
      @(posedge clk);
      if (s_valid && load_en) idx++;
      #1;
      if (idx >= 2) begin
        n_assert++;
        if (config_layer_num !== 32'd3 || config_neuron_num !== 32'd7) begin
          n_fail++;
          $display("FAIL stall_config: got layer=%h neuron=%h expected 3 7", config_layer_num, config_neuron_num);
        end
      end
      cyc++;
    end
    s_valid = 1'b0;
    n_assert++;
    if (idx != total) begin
      n_fail++;
      $display("FAIL stall_timeout: accepted %0d words expected %0d", idx, total);
    end
    flush_and_check("stall", 1, 16'd1, 1'b0);
  endtask

  task automatic test_zero_count();
    do_reset();
    send(32'h0506_0000);
    send(32'hDEAD);
    if (CSUM != 0) send(32'hBEEF);
    flush_and_check("zero_drop", 0, 16'd0, 1'b1);
    send_good(32'h0506_0002, 2, 32'h21, 32'h31, 1'b0);
    flush_and_check("zero_next", 1, 16'd1, 1'b1);
  endtask

  task automatic test_oversize();
    do_reset();
    send(32'h0708_0000 | (MAXW + 1));
    for (int i = 0; i < MAXW + 2 + CSUM; i++) send(32'h4000 + i);
    flush_and_check("over_drop", 0, 16'd0, 1'b1);
    send_good(32'h0708_0001, 1, 32'h99, 32'hAB, 1'b0);
    flush_and_check("over_next", 1, 16'd1, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    exp_layer = 32'd1;
    exp_neuron = 32'd5;
    send(32'h0105_0004);
    wq.push_back(32'h11);
    send(32'h11);
    wq.push_back(32'h12);
    send(32'h12);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_assert++;
    if ({weightValid, biasValid, busy, frame_done, err, frames_loaded, weightValue, biasValue,
         config_layer_num, config_neuron_num} !== '0) begin
      n_fail++;
      $display("FAIL midreset_zero: got wv=%b busy=%b wval=%h layer=%h neuron=%h expected all 0",
               weightValid, busy, weightValue, config_layer_num, config_neuron_num);
    end
    wq.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    done_cnt = 0;
    send_good(32'h0203_0001, 1, 32'h77, 32'h88, 1'b0);
    flush_and_check("midreset_next", 1, 16'd1, 1'b0);
    n_assert++;
    if (config_layer_num !== 32'd2 || config_neuron_num !== 32'd3) begin
      n_fail++;
      $display("FAIL midreset_config: got layer=%h neuron=%h expected 2 3", config_layer_num, config_neuron_num);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_good(32'h0A01_0002, 2, 32'h500, 32'h600, 1'b0);
    send_good(32'h0A02_0003, 3, 32'h700, 32'h800, 1'b0);
    send_good(32'h0B03_0001, 1, 32'h900, 32'hA00, 1'b0);
    flush_and_check("b2b", 3, 16'd3, 1'b0);
  endtask

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    exp_layer = 32'd0;
    exp_neuron = 32'd2;
    send(32'h0002_0001);
    wq.push_back(32'h5);
    send(32'h5);
    bq.push_back(32'h7);
    send(32'h7);
    send(32'h0002_0003);
    flush_and_check("csum_good", 1, 16'd1, 1'b0);
    send(32'h0002_0001);
    wq.push_back(32'h5);
    send(32'h5);
    bq.push_back(32'h7);
    send(32'h7);
    send(32'h0);
    flush_and_check("csum_bad", 1, 16'd1, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_stall();
    test_zero_count();
    test_oversize();
    test_reset_mid();
    test_back_to_back();
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Sources the neuron weight/bias load interface: weightValid, weightValue, biasValid, biasValue, config_layer_num, config_neuron_num.
- Takes a framed 32-bit word stream from the host/DMA side with a valid/ready handshake.
- Parses one frame per neuron: a header word, then the weights, then one bias word.
- Drives the load interface broadcast to every neuron of every layer; each neuron captures only when the layer/neuron numbers match its own.

Parameters:
- maxWeight, 784, largest legal weight count per neuron; larger counts are an error.
- dataWidth, 16, neuron data width; weightValue and biasValue carry data in [dataWidth-1:0], upper bits zero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_en  in  1  stream enable; s_ready follows it.
- s_data  in  32  stream word.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream ready; equals load_en, combinational.
- weightValid  out  1  one-cycle pulse per weight.
- weightValue  out  32  weight word.
- biasValid  out  1  one-cycle pulse per bias.
- biasValue  out  32  bias word.
- config_layer_num  out  32  target layer, zero-extended from header.
- config_neuron_num  out  32  target neuron, zero-extended from header.
- busy  out  1  high from header accept to frame end.
- frame_done  out  1  one-cycle pulse when a good frame completes.
- frames_loaded  out  16  good-frame counter; wraps at 0xFFFF -> 0.
- err  out  1  sticky malformed-frame flag; cleared only by reset.

Behaviour:
- Accept: a word is accepted when s_valid & s_ready. Idle cycles inside a frame are legal and produce no pulses.
- Header layout: [31:24] layer, [23:16] neuron, [15:0] weight count N.
- FSM states: HDR, WEIGHT, BIAS, DRAIN (plus CHK with the optional feature).
  - HDR, good header (1 <= N <= maxWeight): latch layer, neuron, N; busy=1; go to WEIGHT.
  - HDR, N==0: set err; go to DRAIN with 1 word left to drop (the bias).
  - HDR, N>maxWeight: set err; go to DRAIN with N+1 words left to drop.
  - WEIGHT: each accepted word gives weightValue=s_data and weightValid=1 on the next cycle. The remaining count decrements; after the Nth word, go to BIAS.
  - BIAS: the accepted word gives biasValue=s_data and biasValid=1 on the next cycle. frame_done pulses in that same cycle and frames_loaded increments. Go to HDR; busy drops with the frame_done cycle.
  - DRAIN: accepted words are discarded with no valid pulses. When the drop count reaches 0, go to HDR with busy=0. Neither frames_loaded nor frame_done changes.
- Output timing: all outputs except s_ready are registered.
  - config_* change only on a good header accept, and are stable from one cycle after the header until the next good header.
  - The first weightValid therefore never sees stale config.
- Back-to-back frames: a new header may be accepted the cycle after the bias is accepted.
- load_en low mid-frame: pauses the stream; FSM state, counts and config are held.
- Reset, asynchronous and legal mid-frame: FSM to HDR.
  - Zeroed: all pulses, busy, err, frames_loaded, weightValue, biasValue, config_*.
  - The partially loaded neuron must be reset by the system alongside this block.
- Widths: N is held in 16 bits; the drop count needs 17 bits, since N+1 can reach 65536.

Optional Feature:
- Macro WEIGHT_LOADER_CHECKSUM_EN.
- Defined: each frame carries one trailing word after the bias, checked in state CHK.
  - That word must equal the XOR of the header, all weights and the bias.
  - Match: frame_done pulses and frames_loaded increments one cycle after the checksum accept.
  - Mismatch: err is set and there is no frame_done; weights and bias have already been pulsed out.
  - Frames sent to DRAIN drop one extra word (the checksum).
- Undefined: no CHK state, no checksum word, timing exactly as above.

Decomposition:
- Package weight_loader_pkg holds:
  - FSM state enum.
  - Header field positions (layer MSB/LSB, neuron MSB/LSB, count MSB/LSB).
  - CNT_W = 17.
- Natural sub-module: weight_loader_hdr_check, combinational. Header in -> layer, neuron, N, hdr_ok, drop_cnt. Keeps the FSM file to sequencing only.

Test Plan:
- Good frame: header 0x0104_0003, weights 0xA,0xB,0xC, bias 0xE90 -> config_layer_num=1 and config_neuron_num=4 before the first pulse; weightValid 3 pulses with values A,B,C; then biasValid with 0xE90; frame_done once; frames_loaded=1.
- Toggle s_valid and load_en randomly during an N=5 frame -> exactly 5 weightValid pulses in order; config stable throughout; no pulse without an accept.
- Header with N=0 followed by one word -> err=1, no valid pulses. Then a good N=2 frame loads normally and frames_loaded=1.
- Header with N=maxWeight+1 (785) followed by 786 words, then a good frame -> all 786 dropped silently, err=1, the following frame loads.
- Assert rst low after 2 of 4 weights -> all outputs zero immediately. After release, a fresh header is parsed as a header, not as a weight.
- With WEIGHT_LOADER_CHECKSUM_EN: frame 0x0002_0001, 0x5, 0x7 with checksum 0x0002_0003 -> frame_done. Same frame with checksum 0 -> err=1 and no frame_done.
